uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, payload width; legal range 5..8.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port iStartTx  input  1  request to send a frame; level-sampled.
REQ-006 Port iTxData  input  DATA_BITS  payload; captured when a start is accepted.
REQ-007 Port iTxClear  input  1  acknowledges completion and returns the block to idle.
REQ-008 Port oTx  output  1  serial line; idle high; driven from a register.
REQ-009 Port oTxBusy  output  1  high in every state except IDLE.
REQ-010 Port oTxFlag  output  1  high while in TXCOMPLETE.

Function
REQ-011 The state machine SHALL have states IDLE, START, DATA, PARITY (present only with the macro), STOP and TXCOMPLETE.
REQ-012 In IDLE with iStartTx=1, the block SHALL capture iTxData into a shift register and enter START on the next edge.
REQ-013 oTx SHALL go low one cycle after start acceptance and stay low for exactly CLKS_PER_BIT cycles (START).
REQ-014 DATA SHALL shift DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles, using a bit counter of width clog2(DATA_BITS).
REQ-015 STOP SHALL drive oTx=1 for CLKS_PER_BIT cycles, then enter TXCOMPLETE.
REQ-016 TXCOMPLETE SHALL hold oTx=1 and oTxFlag=1 until iTxClear=1, then enter IDLE on the next edge.
REQ-017 The baud counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary, and reset to 0 on every state entry.
REQ-018 iStartTx SHALL be ignored outside IDLE, and iTxData changes after capture SHALL NOT affect the frame in flight.
REQ-019 iTxClear outside TXCOMPLETE SHALL be ignored.
REQ-020 With iTxClear and iStartTx both high in TXCOMPLETE, clear SHALL win; start is accepted only if still high in IDLE.
REQ-021 Without the macro, a frame SHALL last (DATA_BITS+2)*CLKS_PER_BIT cycles from the first low oTx cycle to TXCOMPLETE entry.
REQ-022 Illegal state encodings SHALL return to IDLE on the next edge with oTx=1.

Reset
REQ-023 While reset=1 at a clock edge, the block SHALL set state=IDLE, oTx=1, oTxBusy=0, oTxFlag=0, and clear the counters and shift register.
REQ-024 Reset mid-frame SHALL abort the frame; oTx SHALL be high on the cycle after the reset edge.
REQ-025 Reset SHALL have priority over every other input.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY state between DATA and STOP drives the even parity of the captured payload for CLKS_PER_BIT cycles, and the frame is (DATA_BITS+3)*CLKS_PER_BIT cycles.
REQ-027 Macro UART_TX_PARITY_EN undefined: no PARITY state and no parity logic exists; DATA proceeds directly to STOP.

Structure
REQ-028 The state enumeration and the default CLKS_PER_BIT/DATA_BITS values SHALL live in shared package uart_pkg, which the RX side also uses.
REQ-029 The baud counter SHALL be a sub-module uart_baud_tick (inputs clk, reset, clear; output tick at terminal count).
REQ-030 The FSM, shift register and bit counter SHALL stay in uart_tx_ctrl.

Verification (CLKS_PER_BIT=4, DATA_BITS=8)
REQ-031 iTxData=0xA5, 1-cycle iStartTx, macro off -> oTx sequence in 4-cycle bits is 0,1,0,1,0,0,1,0,1,1; oTxFlag rises 40 cycles after the first low oTx cycle.
REQ-032 Same stimulus with UART_TX_PARITY_EN -> parity bit 0 after the data bits, then stop 1; frame is 44 cycles.
REQ-033 iTxData=0x07 with the macro on -> parity bit 1.
REQ-034 Change iTxData and pulse iStartTx mid-frame -> the frame is unchanged and no second frame starts.
REQ-035 Assert reset in the DATA state at bit 3 -> oTx=1, oTxBusy=0 next cycle; a later start sends a full clean frame.
REQ-036 In TXCOMPLETE, assert iTxClear and iStartTx together for 1 cycle -> IDLE, no new frame; hold iStartTx 1 more cycle -> a new frame begins.

Source files
------------

// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkg: state encoding and default parameters shared by UART TX and RX. |
// | Optional macro: UART_TX_PARITY_EN adds the PARITY state.                  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY     = 3'd3,
`endif
    STOP       = 3'd4,
    TXCOMPLETE = 3'd5
  } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// +--------------------------------------------------------------------------+
// | uart_baud_tick: bit-period counter, 0..CLKS_PER_BIT-1, tick at terminal.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  // Wrap at the bit boundary; clear forces alignment on state entry.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// +--------------------------------------------------------------------------+
// | uart_tx_ctrl: UART transmitter FSM, shift register and bit counter.       |
// | Optional macro: UART_TX_PARITY_EN inserts an even-parity bit before STOP. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iStartTx,
  input  logic [DATA_BITS-1:0] iTxData,
  input  logic                 iTxClear,
  output logic                 oTx,
  output logic                 oTxBusy,
  output logic                 oTxFlag
);

  localparam int               BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 baud_clear;
  logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // Counter held at zero while waiting and restarted on every state change.
  assign baud_clear = (state_d != state_q) || (state_q == IDLE) || (state_q == TXCOMPLETE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (iStartTx) begin
          shift_d  = iTxData;
`ifdef UART_TX_PARITY_EN
          parity_d = ^iTxData;
`endif
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d      = parity_q;
            state_d   = PARITY;
`else
            tx_d      = 1'b1;
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          state_d = TXCOMPLETE;
        end
      end
      TXCOMPLETE: begin
        tx_d = 1'b1;
        if (iTxClear) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign oTx     = tx_q;
  assign oTxBusy = (state_q != IDLE);
  assign oTxFlag = (state_q == TXCOMPLETE);

endmodule

`default_nettype wire
